conv3x3_stream: RTL and testbench

CONV3X3_STREAM -- requirements
Module: conv3x3_stream

---
 rtl/conv3x3_stream.sv | 159 +++++++++++++++
 tb/tb_conv3x3_stream.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution over a raster pixel stream: two line buffers feed a 3x3 window,
// and a second register stage applies the selected kernel per channel with frame-edge masking.
module conv3x3_stream #(
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240,
    parameter int PIX_W      = 8,
    parameter int CH         = 3
) (
    input  logic                clk_50M,
    input  logic                rst,
    input  logic [1:0]          mode,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic                s_sof,
    input  logic [CH*PIX_W-1:0] s_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic                m_sof,
    output logic [CH*PIX_W-1:0] m_data
);

    localparam int DW = CH * PIX_W;
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int AW = PIX_W + 5;

    localparam logic [CW-1:0]        COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0]        ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic signed [AW-1:0] PIX_MAX  = AW'((1 << PIX_W) - 1);

    typedef enum logic [1:0] {
        K_IDENT = 2'd0,
        K_GAUSS = 2'd1,
        K_LAPL  = 2'd2,
        K_SHARP = 2'd3
    } kernel_e;

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    kernel_e       r_active_mode;

    logic          r_v1;
    logic          r_sof1;
    logic          r_mask1;
    kernel_e       r_mode1;

    logic [DW-1:0] r_lb_a [0:IMG_WIDTH-1];
    logic [DW-1:0] r_lb_b [0:IMG_WIDTH-1];
    logic [DW-1:0] r_win  [0:2][0:2];

    logic          w_en;
    logic          w_accept;
    logic [CW-1:0] w_col;
    logic [RW-1:0] w_row;
    kernel_e       w_mode;
    logic [DW-1:0] w_result;

    function automatic logic signed [AW-1:0] f_ext(input logic [PIX_W-1:0] p);
        return $signed({5'b0, p});
    endfunction

    assign w_en     = m_ready || !m_valid;
    assign s_ready  = w_en;
    assign w_accept = s_valid && w_en;

    // A sof beat is processed as position (0,0) with the newly sampled kernel.
    assign w_col  = s_sof ? '0 : r_col;
    assign w_row  = s_sof ? '0 : r_row;
    assign w_mode = s_sof ? kernel_e'(mode) : r_active_mode;

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            r_col         <= '0;
            r_row         <= '0;
            r_active_mode <= K_IDENT;
            r_v1          <= 1'b0;
            r_sof1        <= 1'b0;
            r_mask1       <= 1'b0;
            r_mode1       <= K_IDENT;
            m_valid       <= 1'b0;
            m_sof         <= 1'b0;
            m_data        <= '0;
        end else if (w_en) begin
            r_v1    <= s_valid;
            m_valid <= r_v1;
            m_sof   <= r_v1 && r_sof1;
            m_data  <= w_result;
            if (s_valid) begin
                r_sof1        <= s_sof;
                r_mask1       <= (w_row < RW'(2)) || (w_col < CW'(2));
                r_mode1       <= w_mode;
                r_active_mode <= w_mode;
                if (w_col == COL_LAST) begin
                    r_col <= '0;
                    r_row <= (w_row == ROW_LAST) ? '0 : w_row + RW'(1);
                end else begin
                    r_col <= w_col + CW'(1);
                    r_row <= w_row;
                end
            end
        end
    end

    // Line buffers and window hold only pixel data; stale contents are hidden by r_mask1.
    always_ff @(posedge clk_50M) begin
        if (w_accept) begin
            r_lb_b[w_col] <= r_lb_a[w_col];
            r_lb_a[w_col] <= s_data;
            for (int unsigned r = 0; r < 3; r++) begin
                r_win[r][0] <= r_win[r][1];
                r_win[r][1] <= r_win[r][2];
            end
            r_win[0][2] <= r_lb_b[w_col];
            r_win[1][2] <= r_lb_a[w_col];
            r_win[2][2] <= s_data;
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_ch
        logic signed [AW-1:0] w_c;
        logic signed [AW-1:0] w_n4;
        logic signed [AW-1:0] w_k4;
        logic signed [AW-1:0] w_acc;
        logic [PIX_W-1:0]     w_px;

        always_comb begin
            w_c  = f_ext(r_win[1][1][g*PIX_W +: PIX_W]);
            w_n4 = f_ext(r_win[0][1][g*PIX_W +: PIX_W]) + f_ext(r_win[2][1][g*PIX_W +: PIX_W])
                 + f_ext(r_win[1][0][g*PIX_W +: PIX_W]) + f_ext(r_win[1][2][g*PIX_W +: PIX_W]);
            w_k4 = f_ext(r_win[0][0][g*PIX_W +: PIX_W]) + f_ext(r_win[0][2][g*PIX_W +: PIX_W])
                 + f_ext(r_win[2][0][g*PIX_W +: PIX_W]) + f_ext(r_win[2][2][g*PIX_W +: PIX_W]);
            w_acc = '0;
            w_px  = '0;
            case (r_mode1)
                K_IDENT: w_px = r_win[1][1][g*PIX_W +: PIX_W];
                K_GAUSS: begin
                    w_acc = (w_c <<< 2) + (w_n4 <<< 1) + w_k4;
                    w_px  = w_acc[PIX_W+3:4];
                end
                K_LAPL: begin
                    w_acc = (w_c <<< 3) - w_n4 - w_k4;
                    if (w_acc[AW-1]) w_acc = -w_acc;
                    w_px = (w_acc > PIX_MAX) ? '1 : w_acc[PIX_W-1:0];
                end
                K_SHARP: begin
                    w_acc = (w_c <<< 2) + w_c - w_n4;
                    if (w_acc[AW-1])          w_px = '0;
                    else if (w_acc > PIX_MAX) w_px = '1;
                    else                      w_px = w_acc[PIX_W-1:0];
                end
                default: w_px = '0;
            endcase
            if (r_mask1) w_px = '0;
        end

        assign w_result[g*PIX_W +: PIX_W] = w_px;
    end

endmodule

// File: tb/tb_conv3x3_stream.sv
// Bench for conv3x3_stream on an 8x8 frame: directed and randomized streams compared
// against a frame-array reference model of the kernels.
module tb_conv3x3_stream;

    localparam int W = 8;
    localparam int H = 8;

    logic        clk_50M = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic        s_valid;
    logic        s_ready;
    logic        s_sof;
    logic [23:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_sof;
    logic [23:0] m_data;

    conv3x3_stream #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .PIX_W     (8),
        .CH        (3)
    ) dut (
        .clk_50M(clk_50M),
        .rst    (rst),
        .mode   (mode),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_sof  (s_sof),
        .s_data (s_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_sof  (m_sof),
        .m_data (m_data)
    );

    always #5 clk_50M = ~clk_50M;

    typedef struct {
        logic [23:0] d;
        logic        sof;
        int          cyc;
    } exp_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cycle   = 0;
    bit          lat_chk = 1'b1;
    exp_t        q[$];
    logic [23:0] img[H][W];
    int          mr = 0;
    int          mc = 0;
    logic [1:0]  amode = 2'd0;
    bit          prev_stall = 1'b0;
    logic [23:0] prev_data;
    logic        prev_sof;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int px(int r, int c, int ch);
        logic [23:0] p;
        p = img[r][c];
        return int'(p[ch*8 +: 8]);
    endfunction

    // Kernel on the frame window whose bottom-right pixel is (r,c).
    function automatic logic [23:0] ref_pix(int r, int c, logic [1:0] md);
        logic [23:0] res = '0;
        for (int ch = 0; ch < 3; ch++) begin
            int ctr, n4, k4, v;
            ctr = px(r-1, c-1, ch);
            n4  = px(r-2, c-1, ch) + px(r, c-1, ch) + px(r-1, c-2, ch) + px(r-1, c, ch);
            k4  = px(r-2, c-2, ch) + px(r-2, c, ch) + px(r, c-2, ch) + px(r, c, ch);
            case (md)
                2'd0: v = ctr;
                2'd1: v = (4*ctr + 2*n4 + k4) / 16;
                2'd2: begin
                    v = 8*ctr - n4 - k4;
                    if (v < 0) v = -v;
                    if (v > 255) v = 255;
                end
                default: begin
                    v = 5*ctr - n4;
                    if (v < 0) v = 0;
                    if (v > 255) v = 255;
                end
            endcase
            res[ch*8 +: 8] = 8'(v);
        end
        return res;
    endfunction

    task automatic model_accept(input logic sof, input logic [1:0] md, input logic [23:0] d, input int acc_cyc);
        exp_t e;
        if (sof) begin
            mr = 0; mc = 0; amode = md;
        end
        img[mr][mc] = d;
        e.d   = (mr < 2 || mc < 2) ? 24'h0 : ref_pix(mr, mc, amode);
        e.sof = sof;
        e.cyc = acc_cyc;
        q.push_back(e);
        if (mc == W-1) begin
            mc = 0;
            mr = (mr == H-1) ? 0 : mr + 1;
        end else begin
            mc = mc + 1;
        end
    endtask

    task automatic cyc(input logic v, input logic sof, input logic [1:0] md, input logic [23:0] d,
                       input logic rdy, output logic acc);
        exp_t e;
        @(negedge clk_50M);
        s_valid = v; s_sof = sof; mode = md; s_data = d; m_ready = rdy;
        #1;
        acc = v && s_ready;
        chk("s_ready", s_ready, m_ready || !m_valid);
        if (prev_stall) begin
            chk("stall_valid", m_valid, 1);
            chk("stall_data", m_data, prev_data);
            chk("stall_sof", m_sof, prev_sof);
        end
        if (m_valid && m_ready) begin
            chk("beat_expected", q.size() > 0, 1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("m_data", m_data, e.d);
                chk("m_sof", m_sof, e.sof);
                if (lat_chk) chk("latency", cycle - e.cyc, 2);
            end
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_sof   = m_sof;
        @(posedge clk_50M);
        if (acc) model_accept(sof, md, d, cycle);
        cycle++;
    endtask

    function automatic logic [23:0] gen(int kind, int r, int c);
        logic [7:0] v;
        v = 8'(r*W + c);
        case (kind)
            0: return {8'd255 - v, v + 8'd100, v};
            1: return {8'd100, 8'd100, 8'd100};
            2: return (r == 4 && c == 4) ? 24'hFFFFFF : 24'h0;
            default: return 24'($urandom);
        endcase
    endfunction

    task automatic send_pix(input logic sof, input logic [1:0] md, input logic [23:0] d,
                            input int vprob, input int rprob);
        logic acc;
        int   tries;
        logic v, rdy;
        tries = 0;
        do begin
            v   = ($urandom_range(99) < 32'(vprob));
            rdy = ($urandom_range(99) < 32'(rprob));
            cyc(v, sof, sof ? md : 2'($urandom), d, rdy, acc);
            tries++;
        end while (!acc && tries < 200);
        if (!acc) chk("accept_timeout", acc, 1);
    endtask

    task automatic send_frame(input int kind, input logic [1:0] md, input int vprob, input int rprob,
                              input int npix, input logic with_sof);
        for (int i = 0; i < npix; i++)
            send_pix(with_sof && i == 0, md, gen(kind, i / W, i % W), vprob, rprob);
    endtask

    task automatic drain();
        logic acc;
        int   n;
        n = 0;
        while (q.size() > 0 && n < 50) begin
            cyc(1'b0, 1'b0, 2'd0, 24'h0, 1'b1, acc);
            n++;
        end
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; mode = 2'd0; s_valid = 1'b0; s_sof = 1'b0; s_data = '0; m_ready = 1'b1;
        #12;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_sof", m_sof, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_s_ready", s_ready, 1);
        @(negedge clk_50M);
        rst = 1'b0;

        lat_chk = 1'b1;
        send_frame(0, 2'd0, 100, 100, W*H, 1'b1);
        send_frame(1, 2'd1, 100, 100, W*H, 1'b1);
        send_frame(1, 2'd2, 100, 100, W*H, 1'b1);
        send_frame(2, 2'd2, 100, 100, W*H, 1'b1);
        send_frame(2, 2'd3, 100, 100, W*H, 1'b1);
        drain();

        lat_chk = 1'b0;
        for (int f = 0; f < 3; f++)
            send_frame(3, 2'($urandom), 70, 50, W*H, 1'b1);
        drain();

        lat_chk = 1'b1;
        send_frame(0, 2'd0, 100, 100, 3*W + 5, 1'b1);
        send_frame(3, 2'd1, 100, 100, W*H, 1'b1);
        drain();

        send_frame(0, 2'd3, 100, 100, 20, 1'b1);
        @(negedge clk_50M);
        s_valid = 1'b0;
        #1;
        chk("pre_rst_m_valid", m_valid, 1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_m_valid", m_valid, 0);
        chk("async_rst_m_sof", m_sof, 0);
        chk("async_rst_m_data", m_data, 0);
        @(posedge clk_50M);
        @(negedge clk_50M);
        rst = 1'b0;
        q.delete();
        mr = 0; mc = 0; amode = 2'd0;
        prev_stall = 1'b0;
        send_frame(3, 2'd2, 100, 100, W*H, 1'b0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
